// File: rtl/mult_pkg.sv
// mult_pkg - shared definitions for the sequential multiplier.
//   state_e   : FSM encoding (IDLE=0, CALC=1, DONE=2)
//   DEF_WIDTH : default operand width in bits
//   DEF_CNT_W : default iteration counter width (2**DEF_CNT_W > DEF_WIDTH)
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_32_bit.sv
// adder_32_bit - purely combinational ripple-free adder with carry in/out.
// Used for the multiplier's add step and by the ALU add path.
// Ports:
//   A, B  : addends (W bits)
//   Cin   : carry in
//   Sum   : W-bit sum
//   Cout  : carry out of the top bit
module adder_32_bit #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W-1:0] Sum,
    output logic         Cout
);

    // W+1-bit sum so the carry out is kept
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};

endmodule

// File: rtl/mult32_seq.sv
// mult32_seq - sequential unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, sampled only in IDLE or DONE
//   A, B    : multiplicand / multiplier (unsigned, WIDTH bits)
//   busy    : high while the FSM is in CALC
//   done    : one-cycle pulse while the FSM is in DONE
//   Product : full 2*WIDTH product, held until the next DONE entry
// Optional build macro MULT32_EARLY_EXIT_EN: when defined, CALC finishes as
// soon as the remaining unprocessed multiplier bits are all zero.
module mult32_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_e               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     acc_q;
    logic [CNT_W-1:0]     count_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 carry_s;
    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     mplier_d;
    logic [CNT_W-1:0]     count_d;
    logic                 last_s;
    logic                 early_s;
    logic [2*WIDTH-1:0]   early_prod_s;

    // Select the multiplicand only when the current multiplier bit is set
    always_comb begin
        addend_s = '0;
        if (mplier_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = '0;
        end
    end

    adder_32_bit #(
        .W (WIDTH)
    ) u_adder (
        .A    (acc_q),
        .B    (addend_s),
        .Cin  (1'b0),
        .Sum  (sum_s),
        .Cout (carry_s)
    );

    // One shift-add step: {carry, sum, mplier} shifted right by one
    always_comb begin
        acc_d    = {carry_s, sum_s[WIDTH-1:1]};
        mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q + ONE_CNT;
        last_s   = (count_q == LAST_CNT);
    end

`ifdef MULT32_EARLY_EXIT_EN
    localparam logic [CNT_W:0] WIDTH_C = WIDTH[CNT_W:0];

    logic [WIDTH-1:0] rem_mask_s;
    logic [CNT_W:0]   shamt_s;

    // After count_q steps the low WIDTH-count_q bits of mplier_q are still
    // unprocessed; if they are zero no further adds happen, so the final
    // product is the partial product shifted into place in one go.
    always_comb begin
        rem_mask_s   = {WIDTH{1'b1}} >> count_q;
        early_s      = ((mplier_q & rem_mask_s) == {WIDTH{1'b0}});
        shamt_s      = WIDTH_C - {1'b0, count_q};
        early_prod_s = {acc_q, mplier_q} >> shamt_s;
    end
`else
    // Fixed-latency build: never exits early
    always_comb begin
        early_s      = 1'b0;
        early_prod_s = '0;
    end
`endif

    // Control FSM and datapath registers with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= A;
                        mplier_q <= B;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                CALC: begin
                    if (early_s) begin
                        product_q <= early_prod_s;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_d;
                        count_q  <= count_d;
                        if (last_s) begin
                            product_q <= {acc_d, mplier_d};
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            state_q   <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    // Back-to-back accept skips IDLE entirely
                    if (start) begin
                        mcand_q  <= A;
                        mplier_q <= B;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq - directed scoreboard bench for mult32_seq.
// The driver pushes the hand-computed product, acceptance cycle and latency
// expectation when a start is accepted; the monitor pops on every done pulse.
// Honours MULT32_EARLY_EXIT_EN to select latency expectations.
module tb_mult32_seq;

`ifdef MULT32_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // Latency bound for generic ops: exactly 33 edges, or at most 33 with early exit
    localparam int  GEN_LAT   = EARLY ? 34 : 33;
    localparam bit  GEN_EXACT = EARLY ? 1'b0 : 1'b1;
    localparam int  GEN_BUSY  = EARLY ? -1 : 32;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          lat;
        bit          exact;
        int          busy_exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    exp_t sb[$];
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   dones_seen;
    int   n_pushed;
    int   busy_cnt;

    mult32_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (a),
        .B       (b),
        .busy    (busy),
        .done    (done),
        .Product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] p, input int lat, input bit exact, input int bexp);
        exp_t e;
        e.prod     = p;
        e.acc_cyc  = cyc;
        e.lat      = lat;
        e.exact    = exact;
        e.busy_exp = bexp;
        sb.push_back(e);
        n_pushed++;
    endtask

    // Issue one op from IDLE; checks that the DUT accepted it
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] p,
                         input int lat, input bit exact, input int bexp);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        push_exp(p, lat, exact, bexp);
        check("accept_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                dones_seen++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done pulse with Product 0x%016h, none expected", product);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc_cyc + 1;
                    if (product !== e.prod) begin
                        n_fail++;
                        $display("FAIL product: got 0x%016h expected 0x%016h", product, e.prod);
                    end
                    n_chk++;
                    if (e.exact ? (lat != e.lat) : (lat >= e.lat)) begin
                        n_fail++;
                        $display("FAIL latency: got %0d edges, required %s %0d", lat,
                                 e.exact ? "==" : "<", e.lat);
                    end
                    if (e.busy_exp >= 0) begin
                        n_chk++;
                        if (busy_cnt != e.busy_exp) begin
                            n_fail++;
                            $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, e.busy_exp);
                        end
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int snap;
        n_chk      = 0;
        n_fail     = 0;
        dones_seen = 0;
        n_pushed   = 0;
        busy_cnt   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        a          = 32'd0;
        b          = 32'd0;

        // Reset state
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic and boundary operands
        issue(32'd3, 32'd5, 64'd15, GEN_LAT, GEN_EXACT, GEN_BUSY);
        drain(60);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, GEN_LAT, GEN_EXACT, GEN_BUSY);
        drain(60);
        issue(32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, GEN_LAT, GEN_EXACT, GEN_BUSY);
        drain(60);
        issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, GEN_LAT, GEN_EXACT, GEN_BUSY);
        drain(60);
        issue(32'd0, 32'hFFFF_FFFF, 64'd0, GEN_LAT, GEN_EXACT, GEN_BUSY);
        drain(60);

        // Product must hold through IDLE
        repeat (3) @(negedge clk);
        check("product_hold", product, 64'd0);

        // Start while busy is ignored
        issue(32'h0000_1234, 32'h8000_0010, 64'h0000_091A_0001_2340, 33, 1'b1, 32);
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", {63'd0, busy}, 64'd1);
        drain(60);

        // Back-to-back: start held through DONE
        @(negedge clk);
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        push_exp(64'd15, GEN_LAT, GEN_EXACT, GEN_BUSY);
        a = 32'h0001_0000;
        b = 32'h0001_0000;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("b2b_first_done_seen", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        push_exp(64'h0000_0001_0000_0000, GEN_LAT, GEN_EXACT, GEN_BUSY);
        check("b2b_no_idle", {63'd0, busy}, 64'd1);
        start = 1'b0;
        drain(60);

        // Reset mid-CALC aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        a     = 32'd7;
        b     = EARLY ? 32'h8000_0009 : 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        snap  = dones_seen;
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", {63'd0, busy}, 64'd0);
        check("midop_reset_done", {63'd0, done}, 64'd0);
        check("midop_reset_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midop_no_done", 64'(dones_seen - snap), 64'd0);

`ifdef MULT32_EARLY_EXIT_EN
        // Early exit: B=0 finishes in 2 edges, small B well under 33
        issue(32'h0000_1234, 32'd0, 64'd0, 2, 1'b1, 1);
        drain(60);
        issue(32'd5, 32'd3, 64'd15, 33, 1'b0, -1);
        drain(60);
`endif

        check("done_count", 64'(dones_seen), 64'(n_pushed));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
